// File: rtl/sram2axi_rd_mux.sv
// sram2axi_rd_mux
// Merges NPORT SRAM-like read ports onto one AXI AR/R channel pair.
// Requests are granted round-robin into a single AR holding register, and
// the port index is used as ARID. Each port may have up to MAX_OUTS reads in
// flight. Because AXI keeps same-ID responses in order, every port gets its
// data back in request order without a reorder buffer.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   port_req           per-port read request
//   port_size          per-port size (0=byte 1=half 2=word), port i at [2i+1:2i]
//   port_addr          per-port byte address, port i at [32i+31:32i]
//   port_addr_ok       request of that port accepted this cycle (combinational)
//   port_data_ok       one-cycle pulse, read data valid for that port
//   port_rdata         per-port read data, held between beats
//   arid/araddr/arsize/arvalid/arready   AXI read address channel
//   rid/rdata/rvalid/rready              AXI read data channel
//   err                sticky flag: R beat with unknown ID or no read outstanding
module sram2axi_rd_mux #(
  parameter int NPORT    = 2,
  parameter int MAX_OUTS = 4,
  parameter int ID_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NPORT-1:0]      port_req,
  input  logic [2*NPORT-1:0]    port_size,
  input  logic [32*NPORT-1:0]   port_addr,
  output logic [NPORT-1:0]      port_addr_ok,
  output logic [NPORT-1:0]      port_data_ok,
  output logic [32*NPORT-1:0]   port_rdata,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);

  // Registered state
  logic                 arvalid_q;
  logic [ID_W-1:0]      arid_q;
  logic [31:0]          araddr_q;
  logic [2:0]           arsize_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]     cnt_q   [NPORT];
  logic [31:0]          rdata_q [NPORT];
  logic [NPORT-1:0]     data_ok_q;
  logic                 err_q;

  // Per-port views of the packed request buses
  logic [31:0]          addr_arr [NPORT];
  logic [1:0]           size_arr [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign addr_arr[gi]              = port_addr[gi*32 +: 32];
    assign size_arr[gi]              = port_size[gi*2 +: 2];
    assign port_rdata[gi*32 +: 32]   = rdata_q[gi];
  end

  // Arbitration
  logic [NPORT-1:0]     elig;
  logic                 slot_free;
  logic                 grant_vld;
  logic                 grant_en;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     cand;

  assign slot_free = !arvalid_q || arready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    elig      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NPORT; i++) begin
      elig[i] = port_req[i] && (cnt_q[i] < MAX_CNT);
    end
    // Walk from the farthest candidate back to the nearest one after the
    // pointer; the last hit wins, giving first-eligible-after-pointer.
    for (int k = NPORT; k >= 1; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NPORT);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_en = slot_free && grant_vld && !reset;

  always_comb begin
    port_addr_ok = '0;
    for (int i = 0; i < NPORT; i++) begin
      port_addr_ok[i] = grant_en && (grant_idx == PTR_W'(i));
    end
  end

  // R beat qualification; rid is widened so NPORT == 2^ID_W still compares right
  logic                 rid_in_range;
  logic [PTR_W-1:0]     rid_idx;
  logic                 beat_ok;

  assign rid_in_range = ({1'b0, rid} < (ID_W+1)'(NPORT));
  assign rid_idx      = PTR_W'(rid);
  assign beat_ok      = rvalid && rid_in_range && (cnt_q[rid_idx] != '0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      rr_ptr_q  <= PTR_W'(NPORT - 1);
      data_ok_q <= '0;
      err_q     <= 1'b0;
      // NOTE: the per-port data holding registers are reset because their
      // value is visible on port_rdata straight out of reset.
      for (int i = 0; i < NPORT; i++) begin
        cnt_q[i]   <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      // AR holding register: load on grant, clear once accepted and idle
      if (grant_en) begin
        arvalid_q <= 1'b1;
        arid_q    <= ID_W'(grant_idx);
        araddr_q  <= addr_arr[grant_idx];
        arsize_q  <= {1'b0, size_arr[grant_idx]};
        rr_ptr_q  <= grant_idx;
      end else if (arready) begin
        arvalid_q <= 1'b0;
      end

      // R beats are always consumed; bad ones only raise the sticky flag
      data_ok_q <= '0;
      if (beat_ok) begin
        data_ok_q[rid_idx] <= 1'b1;
        rdata_q[rid_idx]   <= rdata;
      end else if (rvalid) begin
        err_q <= 1'b1;
      end

      // Outstanding counters: up on grant, down on the delivered data pulse
      for (int i = 0; i < NPORT; i++) begin
        case ({port_addr_ok[i], data_ok_q[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  assign arvalid      = arvalid_q;
  assign arid         = arid_q;
  assign araddr       = araddr_q;
  assign arsize       = arsize_q;
  assign port_data_ok = data_ok_q;
  assign err          = err_q;
  assign rready       = !reset;

endmodule

// File: tb/tb_sram2axi_rd_mux.sv
// Self-checking bench for sram2axi_rd_mux. A cycle-level reference model
// tracks, per port, how many reads are in flight and what data the port
// should show, and predicts the AR channel from the round-robin rule.
// Stimulus is randomized; R beats are only returned for addresses the AXI
// side has actually accepted, in per-ID order, except in the error phase.
module tb_sram2axi_rd_mux;

  localparam int NPORT    = 2;
  localparam int MAX_OUTS = 4;
  localparam int ID_W     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NPORT-1:0]     port_req;
  logic [2*NPORT-1:0]   port_size;
  logic [32*NPORT-1:0]  port_addr;
  logic [NPORT-1:0]     port_addr_ok;
  logic [NPORT-1:0]     port_data_ok;
  logic [32*NPORT-1:0]  port_rdata;
  logic [ID_W-1:0]      arid;
  logic [31:0]          araddr;
  logic [2:0]           arsize;
  logic                 arvalid;
  logic                 arready;
  logic [ID_W-1:0]      rid;
  logic [31:0]          rdata;
  logic                 rvalid;
  logic                 rready;
  logic                 err;

  sram2axi_rd_mux #(.NPORT(NPORT), .MAX_OUTS(MAX_OUTS), .ID_W(ID_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_req     (port_req),
    .port_size    (port_size),
    .port_addr    (port_addr),
    .port_addr_ok (port_addr_ok),
    .port_data_ok (port_data_ok),
    .port_rdata   (port_rdata),
    .arid         (arid),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_arvalid;
  int          m_arid;
  logic [31:0] m_araddr;
  int          m_arsize;
  int          m_last;            // last granted port
  int          m_inflight [NPORT]; // granted minus delivered
  bit          m_dok      [NPORT];
  logic [31:0] m_data     [NPORT];
  bit          m_err;
  int          pend       [NPORT]; // ARs accepted by AXI, not yet answered
  int          n_grant1;

  function automatic void model_reset();
    m_arvalid = 0; m_arid = 0; m_araddr = '0; m_arsize = 0;
    m_last = NPORT - 1; m_err = 0;
    for (int i = 0; i < NPORT; i++) begin
      m_inflight[i] = 0; m_dok[i] = 0; m_data[i] = '0; pend[i] = 0;
    end
  endfunction

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    int g;
    int p;
    logic [NPORT-1:0] e_aok;
    #1;
    check("arvalid", arvalid, m_arvalid);
    check("araddr", araddr, m_araddr);
    check("arid", arid, m_arid);
    check("arsize", arsize, m_arsize);
    check("err", err, m_err);
    check("rready", rready, !reset);
    for (int i = 0; i < NPORT; i++) begin
      check($sformatf("data_ok%0d", i), port_data_ok[i], m_dok[i]);
      check($sformatf("rdata%0d", i), port_rdata[i*32 +: 32], m_data[i]);
    end
    g = -1;
    if (!reset && (!m_arvalid || arready)) begin
      for (int k = 1; k <= NPORT; k++) begin
        p = (m_last + k) % NPORT;
        if (g < 0 && port_req[p] && m_inflight[p] < MAX_OUTS) g = p;
      end
    end
    e_aok = '0;
    if (g >= 0) e_aok[g] = 1'b1;
    check("addr_ok", port_addr_ok, e_aok);

    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (m_arvalid && arready) pend[m_arid]++;
      if (g == 1) n_grant1++;
      // Delivered pulses retire reads; beat legality uses pre-edge counts
      for (int i = 0; i < NPORT; i++) m_inflight[i] += int'(e_aok[i]) - int'(m_dok[i]);
      for (int i = 0; i < NPORT; i++) m_dok[i] = 0;
      if (rvalid) begin
        if (int'(rid) < NPORT && (m_inflight[rid] - int'(e_aok[rid]) + int'(port_data_ok[rid] && 1'b0)) >= 0
            && (m_inflight[rid] - int'(e_aok[rid]) + int'(m_dok_prev(rid))) != 0) begin
          m_dok[rid]  = 1;
          m_data[rid] = rdata;
        end else begin
          m_err = 1;
        end
      end
      if (g >= 0) begin
        m_arvalid = 1; m_arid = g;
        m_araddr  = port_addr[g*32 +: 32];
        m_arsize  = int'(port_size[g*2 +: 2]);
        m_last    = g;
      end else if (arready) begin
        m_arvalid = 0;
      end
    end
    @(negedge clk);
  endtask

  // Pulse delivered in the cycle just stepped (recorded before clearing)
  bit dok_prev [NPORT];
  function automatic bit m_dok_prev(input logic [ID_W-1:0] id);
    return dok_prev[id];
  endfunction

  task automatic step_rec();
    for (int i = 0; i < NPORT; i++) dok_prev[i] = m_dok[i];
    step();
  endtask

  task automatic drive_random(input int ar_pct, input int beat_pct, input logic [NPORT-1:0] req_mask);
    int start;
    int p;
    port_req = NPORT'($urandom) & req_mask;
    for (int i = 0; i < NPORT; i++) begin
      port_addr[i*32 +: 32] = $urandom;
      port_size[i*2 +: 2]   = 2'($urandom_range(0, 2));
    end
    arready = ($urandom_range(0, 99) < ar_pct);
    rvalid  = 1'b0;
    rid     = '0;
    rdata   = $urandom;
    if ($urandom_range(0, 99) < beat_pct) begin
      start = $urandom_range(0, NPORT - 1);
      for (int k = 0; k < NPORT; k++) begin
        p = (start + k) % NPORT;
        if (!rvalid && pend[p] > 0) begin
          rvalid = 1'b1;
          rid    = ID_W'(p);
          pend[p]--;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    port_req = '0; port_size = '0; port_addr = '0;
    arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0;
  endtask

  int ar_pcts [8] = '{100, 70, 20, 0, 100, 50, 90, 30};

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    for (int i = 0; i < NPORT; i++) dok_prev[i] = 0;
    @(negedge clk);
    step_rec();                      // reset state, reset still asserted
    reset = 1'b0;

    // Single read from port 0
    port_req = 2'b01; port_addr[31:0] = 32'h0000_1000; port_size[1:0] = 2'd2;
    step_rec();
    check("single_arvalid", arvalid, 1'b1);
    check("single_araddr", araddr, 32'h0000_1000);
    check("single_arid", arid, 0);
    check("single_arsize", arsize, 3'd2);
    port_req = '0;
    step_rec();                      // AR accepted here
    rvalid = 1'b1; rid = '0; rdata = 32'hDEAD_BEEF; pend[0]--;
    step_rec();
    rvalid = 1'b0;
    check("single_data_ok", port_data_ok, 2'b01);
    check("single_rdata", port_rdata[31:0], 32'hDEAD_BEEF);
    step_rec();

    // Outstanding limit on port 1 with no R traffic
    n_grant1 = 0;
    port_req = 2'b10; port_addr[63:32] = 32'h0000_2000; port_size[3:2] = 2'd1;
    repeat (8) step_rec();
    check("limit_grants", n_grant1, MAX_OUTS);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678; pend[1]--;
    step_rec();
    rvalid = 1'b0;
    step_rec();                      // data_ok[1] visible, still blocked
    check("limit_blocked", n_grant1, MAX_OUTS);
    step_rec();                      // fifth grant here
    check("limit_fifth", n_grant1, MAX_OUTS + 1);

    // Randomized traffic, varying AR back-pressure
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 150; c++) begin
        drive_random(ar_pcts[blk], 40, '1);
        step_rec();
      end
    end

    // Drain everything that is in flight
    for (int c = 0; c < 40; c++) begin
      drive_random(100, 100, '0);
      step_rec();
    end

    // Unexpected beats: port 1 with nothing outstanding, then an unknown ID
    idle_inputs();
    check("pre_err", err, 1'b0);
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hBAD0_0001;
    step_rec();
    rvalid = 1'b0;
    check("err_set", err, 1'b1);
    check("err_no_data_ok", port_data_ok, 2'b00);
    rvalid = 1'b1; rid = 4'd5; rdata = 32'hBAD0_0005;
    step_rec();
    rvalid = 1'b0;
    repeat (3) step_rec();
    check("err_sticky", err, 1'b1);

    // Reset with reads outstanding
    port_req = 2'b11; arready = 1'b1;
    repeat (3) step_rec();
    reset = 1'b1;
    step_rec();
    reset = 1'b0; idle_inputs();
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data_ok", port_data_ok, 2'b00);
    step_rec();

    // Counters restarted from zero: port 0 gets a full MAX_OUTS again
    for (int c = 0; c < 300; c++) begin
      drive_random(80, 30, '1);
      step_rec();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram2axi_rd_mux.md
Name: sram2axi_rd_mux

Overview:
- Parametrised successor to the fixed inst/data read path of the SRAM-to-AXI bridge.
- Merges NPORT SRAM-like read ports onto one AXI AR/R channel pair.
- Each port may have up to MAX_OUTS reads in flight. Data returns in order per port, and the ARID identifies the port.
- Sits inside the bridge top, replacing the two-port read channel. Constant AXI fields (arlen=0, arburst=INCR, arlock/arcache/arprot=0) are tied off at the bridge top and are not ports here.

Parameters:
NPORT, 2, number of SRAM read ports (1..16); port i uses ARID = i
MAX_OUTS, 4, maximum outstanding reads per port (1..15)
ID_W, 4, AXI ID width; NPORT <= 2^ID_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
port_req  in  NPORT  per-port read request
port_size  in  2*NPORT  per-port size, 0=byte 1=half 2=word (port i at [2i+1:2i])
port_addr  in  32*NPORT  per-port byte address
port_addr_ok  out  NPORT  request accepted this cycle
port_data_ok  out  NPORT  read data valid this cycle (one-cycle pulse)
port_rdata  out  32*NPORT  per-port read data, valid with port_data_ok
arid  out  ID_W  read address ID
araddr  out  32  read address
arsize  out  3  {1'b0, size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rid  in  ID_W  read data ID
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
err  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - arvalid=0, arid/araddr/arsize=0.
  - port_addr_ok=0, port_data_ok=0, port_rdata=0, err=0, rready=0.
  - All outstanding counters=0.
  - RR pointer=NPORT-1, so port 0 has first priority.
  - Reset mid-operation drops arvalid and all counters immediately. In-flight R beats after reset are then unexpected (see err). Whole-system reset is assumed.
- AR slot: a single holding register.
  - "free" = (!arvalid) || (arvalid && arready).
- Eligibility: port i is eligible when port_req[i] && cnt[i] < MAX_OUTS.
- Arbitration (combinational):
  - When the slot is free, grant the first eligible port strictly after the RR pointer, wrapping modulo NPORT.
  - port_addr_ok[g]=1 in the same cycle; all other port_addr_ok bits are 0.
  - On that edge: arvalid<=1, arid<=g, araddr<=port_addr[g], arsize<={0,port_size[g]}, RR pointer<=g.
  - If no port is granted and arready is high, arvalid<=0.
- AR stability: arvalid/araddr/arid remain stable until arready (AXI rule). Back-to-back issue at one request per cycle is possible while arready stays high.
- Latency: request to arvalid is 1 cycle.
- rready: 1 whenever not in reset. R beats are never back-pressured; the SRAM side cannot stall.
- R beat handling (rvalid && rid < NPORT && cnt[rid] != 0):
  - Next cycle: port_data_ok[rid]=1 and port_rdata[rid]<=rdata. Latency is 1 cycle from the R beat.
  - port_rdata holds its value between beats.
- Counters:
  - cnt[i] increments on port_addr_ok[i] and decrements on the registered data_ok event for port i.
  - Both events in the same cycle: unchanged.
  - Width: clog2(MAX_OUTS+1).
  - cnt == MAX_OUTS blocks further grants to that port; other ports continue.
- Unexpected beat (rid >= NPORT, or cnt[rid]==0 at the beat): beat consumed, no data_ok, err<=1. err clears only on reset.
- rresp and rlast are ignored (single-beat reads, OKAY assumed).
- Ordering: relies on AXI same-ID ordering, so per-port data order equals request order. No reordering buffer is required.
- NPORT=1: arbiter degenerates to pass-through; same timing applies.

Test Plan:
- Single read: port0 req addr 0x1000 size 2, arready=1 → addr_ok[0] cycle 0, arvalid/araddr=0x1000/arid=0/arsize=2 cycle 1; R beat rid=0 rdata=0xDEADBEEF → data_ok[0] and rdata0=0xDEADBEEF 1 cycle later.
- Round-robin: ports 0 and 1 both req continuously, arready=1 → grants alternate 0,1,0,1; arids match; no port starved.
- Outstanding limit: MAX_OUTS=4, port1 req 6 times, no R beats → exactly 4 addr_ok[1]. Return rid=1 beat → 5th accepted 1 cycle after its data_ok.
- AR stall: arready=0 for 5 cycles with arvalid=1 → araddr/arid stable, no addr_ok pulses. arready=1 → next grant same cycle.
- Out-of-order IDs: issue p0 A, p1 B; return rid=1 then rid=0 → data_ok[1] then data_ok[0] with correct data; counters both reach 0.
- Error/reset: R beat rid=1 with cnt[1]=0 → no data_ok, err=1 sticky. Reset asserted with 3 reads outstanding → all counters 0, arvalid=0, err=0 next cycle.
